// File: rtl/modemux_arb_hs.sv
// modemux_arb_hs: N-channel arbitrating multiplexer with valid/ready on
// every input and on the output. Arbitration is fixed priority (mode=0,
// ch0 highest) or round-robin (mode=1), and the winner is captured in one
// output register stage.
//
// Optional feature macro: MODEMUX_STARVE_EN
//   When defined, fixed mode gains per-channel starvation counters. A
//   requesting channel that has lost STARVE_LIMIT fixed-mode arbitrations
//   overrides plain priority; the lowest-index such channel wins.
module modemux_arb_hs #(
    parameter int NUM_CH       = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [NUM_CH-1:0]            grant,
    output logic [$clog2(NUM_CH)-1:0]    grant_idx
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [NUM_CH-1:0]     grant_q,     grant_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]      rr_ptr_q,    rr_ptr_d;

    logic                  load;
    logic                  any_valid;
    logic                  accept;
    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [NUM_CH-1:0]     rr_mask;
    logic [NUM_CH-1:0]     rr_masked;
    logic [IDX_W-1:0]      rr_win;
    logic [IDX_W-1:0]      fixed_win;
    logic [IDX_W-1:0]      win_idx;
    logic [NUM_CH-1:0]     win_onehot;
    logic [IDX_W-1:0]      rr_next;

    // Index of the lowest set bit of req; 0 when req is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH-1:0] req);
        lowest_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // Unpack the flattened payload bus into per-channel words.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // The output register can take a new word when empty or being drained.
    assign load      = !out_valid_q || out_ready;
    assign any_valid = |in_valid;
    assign accept    = load && any_valid;

    // Round-robin: prefer requests at or above the pointer, else wrap to the lowest.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            rr_mask[i] = (i >= int'(rr_ptr_q));
        end
        rr_masked = in_valid & rr_mask;
        rr_win    = (|rr_masked) ? lowest_idx(rr_masked) : lowest_idx(in_valid);
    end

`ifdef MODEMUX_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]  starve_q [NUM_CH];
    logic [CNT_W-1:0]  starve_d [NUM_CH];
    logic [NUM_CH-1:0] starving;

    // Fixed priority, overridden by the lowest-index requesting starved channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            starving[i] = in_valid[i] && (starve_q[i] >= CNT_MAX);
        end
        fixed_win = (|starving) ? lowest_idx(starving) : lowest_idx(in_valid);
    end

    // Count lost fixed-mode arbitrations per requester; RR mode clears all.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            starve_d[i] = starve_q[i];
            if (mode) begin
                starve_d[i] = '0;
            end else if (accept) begin
                if (win_onehot[i]) begin
                    starve_d[i] = '0;
                end else if (in_valid[i] && (starve_q[i] != CNT_MAX)) begin
                    starve_d[i] = starve_q[i] + 1'b1;
                end
            end
        end
    end

    // Starvation counter state.
    // NOTE: the counter array is small and its contents steer arbitration, so
    // every entry gets an explicit reset value rather than being left as RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) starve_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) starve_q[i] <= starve_d[i];
        end
    end
`else
    assign fixed_win = lowest_idx(in_valid);
`endif

    assign win_idx    = mode ? rr_win : fixed_win;
    assign win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
    assign rr_next    = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;

    // Accept is combinational so the winner sees ready in the request cycle.
    assign in_ready = (accept && !rst) ? win_onehot : '0;

    // Next state of the output register and the round-robin pointer.
    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            if (any_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = ch_data[win_idx];
                grant_d     = win_onehot;
                grant_idx_d = win_idx;
                if (mode) rr_ptr_d = rr_next;
            end else begin
                out_valid_d = 1'b0;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        end
    end

    // Output register and pointer; reset discards any pending word.
    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_modemux_arb_hs.sv
// tb_modemux_arb_hs: directed scenarios followed by randomized traffic for
// modemux_arb_hs, compared each cycle against a transaction-level model.
// Honours MODEMUX_STARVE_EN the same way the design does.
module tb_modemux_arb_hs;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int LIM = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            mode;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [N-1:0]    grant;
    logic [1:0]      grant_idx;

    int checks   = 0;
    int failures = 0;

    // Reference model state: contents of the output register, RR pointer,
    // loss counters, and the channel accepted in the last cycle.
    bit          m_valid;
    logic [DW-1:0] m_data;
    int          m_idx;
    int          m_ptr;
    int          m_cnt [N];
    int          last_acc;

    int          exp6 [8];

    always #5 clk = ~clk;

    modemux_arb_hs #(
        .NUM_CH      (N),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_valid  = 1'b0;
        m_data   = '0;
        m_idx    = 0;
        m_ptr    = 0;
        last_acc = -1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // Winner chosen from the rules: fixed = first requester from ch0
    // (starved requesters first when enabled); RR = first requester when
    // walking from the pointer around the ring. -1 when nobody requests.
    function automatic int mdl_winner();
        int w;
        w = -1;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (w < 0 && in_valid[c]) w = c;
            end
        end else begin
`ifdef MODEMUX_STARVE_EN
            for (int i = 0; i < N; i++) begin
                if (w < 0 && in_valid[i] && m_cnt[i] >= LIM) w = i;
            end
`endif
            for (int i = 0; i < N; i++) begin
                if (w < 0 && in_valid[i]) w = i;
            end
        end
        return w;
    endfunction

    task automatic chk_out(input string tag);
        logic [N-1:0] eg;
        eg = m_valid ? (N'(1) << m_idx) : '0;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, "_out_data"},  32'(out_data),  32'(m_data));
        check({tag, "_grant"},     32'(grant),     32'(eg));
        check({tag, "_grant_idx"}, 32'(grant_idx), 32'(m_valid ? m_idx : 0));
    endtask

    // One clock cycle: inputs were driven at the preceding falling edge.
    task automatic tick(input string tag);
        int           w;
        bit           load;
        logic [N-1:0] exp_rdy;
        #1;
        load    = !m_valid || out_ready;
        w       = mdl_winner();
        exp_rdy = (!rst && load && w >= 0) ? (N'(1) << w) : '0;
        check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        last_acc = -1;
        if (rst) begin
            mdl_reset();
        end else begin
            if (load) begin
                if (w >= 0) begin
                    m_valid  = 1'b1;
                    m_data   = in_data[w*DW +: DW];
                    m_idx    = w;
                    last_acc = w;
                    if (mode) begin
                        m_ptr = (w + 1) % N;
                    end else begin
`ifdef MODEMUX_STARVE_EN
                        for (int i = 0; i < N; i++) begin
                            if (i == w) m_cnt[i] = 0;
                            else if (in_valid[i] && m_cnt[i] < LIM) m_cnt[i]++;
                        end
`endif
                    end
                end else begin
                    m_valid = 1'b0;
                    m_idx   = 0;
                end
            end
            if (mode) begin
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end
        end
        #1;
        chk_out(tag);
        @(negedge clk);
    endtask

    task automatic drive(input bit md, input logic [N-1:0] v, input bit rdy);
        mode      = md;
        in_valid  = v;
        out_ready = rdy;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'b1111, 1'b0);
        in_data = '0;
        mdl_reset();
`ifdef MODEMUX_STARVE_EN
        exp6 = '{0, 0, 0, 1, 0, 0, 0, 1};
`else
        exp6 = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        @(negedge clk);

        // Reset state, with requests present: in_ready must stay low.
        repeat (2) tick("reset");
        rst = 1'b0;

        // Fixed priority: ch1 wins over ch2/ch3, then ch2 once ch1 drops.
        rand_data();
        drive(1'b0, 4'b1110, 1'b1);
        repeat (4) tick("t2_fixed");
        drive(1'b0, 4'b1100, 1'b1);
        repeat (2) tick("t2_drop");

        // Asynchronous reset with a word pending in the output register.
        check("t1_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_grant",     32'(grant),     32'd0);
        check("t1_out_data",  32'(out_data),  32'd0);
        check("t1_in_ready",  32'(in_ready),  32'd0);
        mdl_reset();
        repeat (2) tick("t1_hold");
        rst = 1'b0;

        // Round-robin over a full load: A0,A1,A2,A3 then wrap to A0.
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive(1'b1, 4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick("t3_rr");
            check("t3_seq", 32'(out_data), 32'(8'hA0 + k % 4));
        end

        // Stall three cycles: register holds A0, then A1 follows on release.
        drive(1'b1, 4'b1111, 1'b0);
        repeat (3) begin
            tick("t4_stall");
            check("t4_stable", 32'(out_data), 32'h0A0);
        end
        drive(1'b1, 4'b1111, 1'b1);
        tick("t4_release");
        check("t4_next", 32'(out_data), 32'h0A1);

        // Mode switch: pointer parked at 2, fixed picks ch0, RR resumes at ch2.
        drive(1'b1, 4'b0010, 1'b1);
        tick("t5_park");
        drive(1'b0, 4'b1101, 1'b1);
        tick("t5_fixed");
        check("t5_fixed_win", 32'(grant_idx), 32'd0);
        drive(1'b1, 4'b1101, 1'b1);
        tick("t5_rr");
        check("t5_rr_win", 32'(grant_idx), 32'd2);

        // Starvation: ch1 breaks through every fourth grant when enabled.
        rst = 1'b1;
        tick("t6_reset");
        rst = 1'b0;
        drive(1'b0, 4'b0011, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick("t6_fixed");
            check("t6_seq", 32'(grant_idx), 32'(exp6[k]));
        end

        // Randomized traffic: sources keep unaccepted requests (usually)
        // and their payloads; mode flips occasionally.
        for (int n = 0; n < 400; n++) begin
            logic [N-1:0] nv;
            if ($urandom_range(15) == 0) mode = ~mode;
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && i != last_acc) begin
                    nv[i] = ($urandom_range(7) != 0);
                end else begin
                    nv[i] = 1'($urandom_range(1));
                    in_data[i*DW +: DW] = DW'($urandom);
                end
            end
            in_valid  = nv;
            out_ready = ($urandom_range(3) != 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
